// File: rtl/fetch_unit.sv
// fetch_unit: program counter and 1/2-byte instruction fetch with valid/ready issue; optional halt stop enabled by FETCH_HALT_EN
module fetch_unit #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter logic [15:0] LONG_MASK   = 16'h000C,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] pc,
  input  logic [7:0]  program_byte,
  input  logic        load_pc,
  input  logic [11:0] load_addr,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_operand,
  output logic        instr_long,
  output logic [11:0] instr_pc,
  output logic        halted
);
`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {OP, OPND, HOLD, HALTED} state_t;
`else
  typedef enum logic [1:0] {OP, OPND, HOLD} state_t;
`endif
  state_t      state, state_n;
  logic [11:0] pc_n, instr_pc_n;
  logic [7:0]  opcode_n, operand_n;
  logic        valid_n, long_n;
`ifdef FETCH_HALT_EN
  logic        halted_n, halt_hit;
  assign halt_hit = instr_ready && !instr_long && instr_opcode == HALT_OPCODE;
`endif
  // next-state and datapath: redirect wins over sequencing; valid is raised on entry to HOLD
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    valid_n    = instr_valid;
    opcode_n   = instr_opcode;
    operand_n  = instr_operand;
    long_n     = instr_long;
    instr_pc_n = instr_pc;
`ifdef FETCH_HALT_EN
    halted_n   = halted;
`endif
    if (load_pc) begin
      state_n = OP;
      pc_n    = load_addr;
      valid_n = 1'b0;
`ifdef FETCH_HALT_EN
      halted_n = 1'b0;
`endif
    end else begin
      case (state)
        OP: begin
          opcode_n   = program_byte;
          instr_pc_n = pc;
          pc_n       = pc + 12'd1;
          long_n     = LONG_MASK[program_byte[7:4]];
          operand_n  = LONG_MASK[program_byte[7:4]] ? instr_operand : 8'h00;
          state_n    = LONG_MASK[program_byte[7:4]] ? OPND : HOLD;
          valid_n    = !LONG_MASK[program_byte[7:4]];
        end
        OPND: begin
          operand_n = program_byte;
          pc_n      = pc + 12'd1;
          state_n   = HOLD;
          valid_n   = 1'b1;
        end
        HOLD: begin
          valid_n = !instr_ready;
`ifdef FETCH_HALT_EN
          state_n  = halt_hit ? HALTED : instr_ready ? OP : HOLD;
          halted_n = halt_hit;
`else
          state_n  = instr_ready ? OP : HOLD;
`endif
        end
        default: state_n = state;
      endcase
    end
  end
  // state and instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= OP;
      pc            <= RESET_PC;
      instr_valid   <= 1'b0;
      instr_opcode  <= 8'h00;
      instr_operand <= 8'h00;
      instr_long    <= 1'b0;
      instr_pc      <= 12'h000;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      instr_valid   <= valid_n;
      instr_opcode  <= opcode_n;
      instr_operand <= operand_n;
      instr_long    <= long_n;
      instr_pc      <= instr_pc_n;
    end
  end
`ifdef FETCH_HALT_EN
  // halt flag follows entry to / exit from the halted state
  always_ff @(posedge clk) begin
    if (reset) halted <= 1'b0;
    else halted <= halted_n;
  end
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; monitor pops expected instructions on each accepted issue
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pc;
  logic [7:0]  program_byte;
  logic        load_pc;
  logic [11:0] load_addr;
  logic        instr_ready;
  logic        instr_valid;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_operand;
  logic        instr_long;
  logic [11:0] instr_pc;
  logic        halted;
  logic [7:0]  rom [4096];
  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  opnd;
    logic        lng;
    logic [11:0] ipc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passes = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .program_byte(program_byte),
    .load_pc(load_pc), .load_addr(load_addr), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_long(instr_long), .instr_pc(instr_pc), .halted(halted)
  );

  assign program_byte = rom[pc];
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted instruction must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_issue: got op=%h pc=%h expected none", instr_opcode, instr_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("issue", {instr_opcode, instr_operand, instr_long, instr_pc}, {e.op, e.opnd, e.lng, e.ipc});
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h15; rom[12'h001] = 8'h27; rom[12'h002] = 8'h41; rom[12'h003] = 8'h99;
    rom[12'h004] = 8'h05; rom[12'hFFF] = 8'h3A; rom[12'h123] = 8'h42;
    reset = 1'b1; load_pc = 1'b0; load_addr = 12'h000; instr_ready = 1'b1;
    step(); step();
    chk("rst_state", {pc, instr_valid, instr_opcode, instr_operand, instr_long, instr_pc, halted},
        {12'h000, 1'b0, 8'h00, 8'h00, 1'b0, 12'h000, 1'b0});
    q.push_back('{8'h15, 8'h00, 1'b0, 12'h000});
    q.push_back('{8'h27, 8'h41, 1'b1, 12'h001});
    q.push_back('{8'h99, 8'h00, 1'b0, 12'h003});
    reset = 1'b0;
    step(); chk("p1_valid", instr_valid, 1);
    step(); chk("p2_valid", instr_valid, 0);
    step(); chk("p3_opnd", {instr_valid, pc}, {1'b0, 12'h002});
    step(); chk("p4_long", {instr_valid, pc}, {1'b1, 12'h003});
    step(); chk("p5_valid", instr_valid, 0);
    step(); chk("p6_short", {instr_valid, instr_opcode}, {1'b1, 8'h99});
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", {instr_valid, instr_opcode, instr_operand, instr_long, instr_pc, pc},
          {1'b1, 8'h99, 8'h00, 1'b0, 12'h003, 12'h004});
    end
    instr_ready = 1'b1;
    q.push_back('{8'h05, 8'h00, 1'b0, 12'h004});
    step(); chk("stall_release", {instr_valid, pc}, {1'b0, 12'h004});
    step(); chk("after_stall", {instr_valid, instr_pc}, {1'b1, 12'h004});
    step();
    rom[12'h000] = 8'h10;
    load_pc = 1'b1; load_addr = 12'hFFF;
    step(); load_pc = 1'b0;
    chk("jump_fff", {instr_valid, pc}, {1'b0, 12'hFFF});
    q.push_back('{8'h3A, 8'h10, 1'b1, 12'hFFF});
    step(); chk("wrap_opnd_pc", pc, 12'h000);
    step(); chk("wrap_issue", {instr_valid, pc}, {1'b1, 12'h001});
    step(); step(); chk("mid_opnd", {instr_valid, pc}, {1'b0, 12'h002});
    load_pc = 1'b1; load_addr = 12'h123;
    step(); load_pc = 1'b0;
    chk("mid_redirect", {instr_valid, pc}, {1'b0, 12'h123});
    step();
    chk("redirect_issue", {instr_valid, instr_opcode, instr_long, instr_pc}, {1'b1, 8'h42, 1'b0, 12'h123});
    instr_ready = 1'b0; reset = 1'b1;
    step();
    chk("rst_in_hold", {instr_valid, pc, instr_opcode, instr_operand, instr_long, instr_pc},
        {1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 12'h000});
    rom[12'h000] = 8'hFF; rom[12'h001] = 8'h15; rom[12'h002] = 8'h00;
    reset = 1'b0; instr_ready = 1'b1;
    q.push_back('{8'hFF, 8'h00, 1'b0, 12'h000});
    step(); chk("halt_issue", {instr_valid, instr_opcode}, {1'b1, 8'hFF});
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halted_hold", {halted, pc, instr_valid}, {1'b1, 12'h001, 1'b0});
    end
    load_pc = 1'b1; load_addr = 12'h000;
    q.push_back('{8'hFF, 8'h00, 1'b0, 12'h000});
    step(); load_pc = 1'b0;
    chk("halt_exit", {halted, pc}, {1'b0, 12'h000});
    step(); chk("halt_refetch", {instr_valid, instr_opcode, halted}, {1'b1, 8'hFF, 1'b0});
    step(); chk("halt_again", {halted, instr_valid}, {1'b1, 1'b0});
`else
    q.push_back('{8'h15, 8'h00, 1'b0, 12'h001});
    step(); chk("nohalt_next", {halted, instr_valid, pc}, {1'b0, 1'b0, 12'h001});
    step(); chk("nohalt_issue", {halted, instr_valid, instr_opcode}, {1'b0, 1'b1, 8'h15});
    step(); instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nohalt_flag", halted, 0);
    end
`endif
    step();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
